// File: rtl/synth_pkg.sv
// Shared constants and types for the synthesizer audio output stage.
package synth_pkg;

   // Field positions inside a 16-bit voice control register
   localparam int EN_BIT  = 15;
   localparam int VOL_MSB = 14;
   localparam int VOL_LSB = 12;
   localparam int P_MSB   = 11;

   localparam int NUM_CH      = 8;
   localparam int CARRIER_MAX = 55;
   localparam int MIX_W       = 6;

   typedef struct packed {
      logic        en;
      logic [2:0]  vol;
      logic [11:0] period;
   } voice_ctrl_t;

   // Split a raw register word into its control fields
   function automatic voice_ctrl_t to_ctrl(input logic [15:0] raw);
      voice_ctrl_t c;
      c.en     = raw[EN_BIT];
      c.vol    = raw[VOL_MSB:VOL_LSB];
      c.period = raw[P_MSB:0];
      return c;
   endfunction

endpackage

// File: rtl/pwm_voice.sv
// One square-wave voice: a half-period down-counter that toggles the square
// bit each time it expires, plus the gated volume it contributes to the mix.
module pwm_voice
   import synth_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  voice_ctrl_t ctrl,
   output logic        sq,
   output logic [2:0]  amp
);

   logic [11:0] cnt;
   logic        active;

   assign active = ctrl.en && (ctrl.period != 12'd0);

   // Counter/square update; an inactive voice is cleared without waiting for a tick
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 12'd0;
         sq  <= 1'b0;
      end else if (!active) begin
         cnt <= 12'd0;
         sq  <= 1'b0;
      end else if (tick) begin
         if ((cnt == 12'd0) || (cnt > ctrl.period)) begin
            // fresh start or period lowered below the running count: reload, keep phase bit
            cnt <= ctrl.period;
         end else if (cnt == 12'd1) begin
            sq  <= ~sq;
            cnt <= ctrl.period;
         end else begin
            cnt <= cnt - 12'd1;
         end
      end
   end

   // Volume only reaches the mixer while the voice is active and high
   assign amp = (active && sq) ? ctrl.vol : 3'd0;

endmodule

// File: rtl/pwm_synth_out.sv
// Audio output stage: eight square-wave voices summed into a 6-bit level that
// drives a 56-clock PWM carrier on the audio pin.
module pwm_synth_out #(
   parameter int TICK_DIV = 50,
   parameter int NUM_CH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pwm_reg0,
   input  logic [15:0] pwm_reg1,
   input  logic [15:0] pwm_reg2,
   input  logic [15:0] pwm_reg3,
   input  logic [15:0] pwm_reg4,
   input  logic [15:0] pwm_reg5,
   input  logic [15:0] pwm_reg6,
   input  logic [15:0] pwm_reg7,
   output logic        audio_pwm,
   output logic        sample_strobe,
   output logic [5:0]  mix_level,
   output logic [7:0]  chan_sq
);

   import synth_pkg::*;

   localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [MIX_W-1:0]  car_cnt;
   logic              car_wrap;
   logic [MIX_W-1:0]  sum;
   logic [15:0]       raw [NUM_CH];
   logic [2:0]        amp [NUM_CH];
   logic [NUM_CH-1:0] sq_vec;

   assign raw[0] = pwm_reg0;
   assign raw[1] = pwm_reg1;
   assign raw[2] = pwm_reg2;
   assign raw[3] = pwm_reg3;
   assign raw[4] = pwm_reg4;
   assign raw[5] = pwm_reg5;
   assign raw[6] = pwm_reg6;
   assign raw[7] = pwm_reg7;

   assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

   // Voice tick prescaler
   always_ff @(posedge clk) begin
      if (rst || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
      pwm_voice u_voice (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .ctrl (to_ctrl(raw[i])),
         .sq   (sq_vec[i]),
         .amp  (amp[i])
      );
   end

   assign chan_sq = sq_vec;

   // Adder tree over voice amplitudes; 8 x 7 = 56 fits in 6 bits
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum = sum + MIX_W'(amp[i]);
      end
   end

   assign car_wrap      = (car_cnt == MIX_W'(CARRIER_MAX));
   assign sample_strobe = car_wrap;

   // Carrier counter, mix latch at wrap, and registered PWM comparator
   always_ff @(posedge clk) begin
      if (rst) begin
         car_cnt   <= '0;
         mix_level <= '0;
         audio_pwm <= 1'b0;
      end else begin
         car_cnt   <= car_wrap ? '0 : car_cnt + MIX_W'(1);
         if (car_wrap) begin
            mix_level <= sum;
         end
         audio_pwm <= (car_cnt < mix_level);
      end
   end

endmodule

// File: tb/tb_pwm_synth_out.sv
// Directed bench for pwm_synth_out with TICK_DIV = 4.
module tb_pwm_synth_out;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] regs [8];
   logic        audio_pwm;
   logic        sample_strobe;
   logic [5:0]  mix_level;
   logic [7:0]  chan_sq;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pwm_synth_out #(.TICK_DIV(TD), .NUM_CH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .pwm_reg0      (regs[0]),
      .pwm_reg1      (regs[1]),
      .pwm_reg2      (regs[2]),
      .pwm_reg3      (regs[3]),
      .pwm_reg4      (regs[4]),
      .pwm_reg5      (regs[5]),
      .pwm_reg6      (regs[6]),
      .pwm_reg7      (regs[7]),
      .audio_pwm     (audio_pwm),
      .sample_strobe (sample_strobe),
      .mix_level     (mix_level),
      .chan_sq       (chan_sq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int i = 0; i < 8; i++) regs[i] = v;
   endtask

   // n reset edges; on return the current cycle is cycle 0 after reset
   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   initial begin
      int spos [3];
      int ns;
      int bad;
      int hi;

      // ---------------- reset and idle ----------------
      set_all(16'h0000);
      do_reset(3);
      check("rst_mix", 32'(mix_level), 0);
      check("rst_audio", 32'(audio_pwm), 0);
      check("rst_chan_sq", 32'(chan_sq), 0);
      check("rst_strobe", 32'(sample_strobe), 0);
      ns = 0;
      bad = 0;
      spos[0] = -1; spos[1] = -1; spos[2] = -1;
      for (int c = 0; c < 200; c++) begin
         if (sample_strobe) begin
            if (ns < 3) spos[ns] = c;
            ns++;
         end
         if (audio_pwm || (mix_level != 6'd0) || (chan_sq != 8'd0)) bad++;
         cyc();
      end
      check("idle_outputs_zero", 32'(bad), 0);
      check("idle_strobe_count", 32'(ns), 3);
      check("idle_strobe0", 32'(spos[0]), 55);
      check("idle_strobe1", 32'(spos[1]), 111);
      check("idle_strobe2", 32'(spos[2]), 167);

      // ---------------- single tone F003 ----------------
      rst = 1'b1;
      regs[0] = 16'hF003;
      do_reset(2);
      bad = 0;
      hi = 0;
      for (int c = 0; c <= 230; c++) begin
         if (c == 15)  check("tone_sq_c15", 32'(chan_sq[0]), 0);
         if (c == 16)  check("tone_sq_c16", 32'(chan_sq[0]), 1);
         if (c == 27)  check("tone_sq_c27", 32'(chan_sq[0]), 1);
         if (c == 28)  check("tone_sq_c28", 32'(chan_sq[0]), 0);
         if (c == 40)  check("tone_sq_c40", 32'(chan_sq[0]), 1);
         if (c == 167) check("tone_mix_c167", 32'(mix_level), 0);
         if (c == 168) check("tone_mix_c168", 32'(mix_level), 7);
         if (c == 223) check("tone_mix_c223", 32'(mix_level), 7);
         if (c == 224) check("tone_mix_c224", 32'(mix_level), 0);
         if (c == 175) check("tone_audio_c175", 32'(audio_pwm), 1);
         if (c == 176) check("tone_audio_c176", 32'(audio_pwm), 0);
         if ((mix_level != 6'd0) && (mix_level != 6'd7)) bad++;
         if ((c >= 169) && (c <= 224) && audio_pwm) hi++;
         cyc();
      end
      check("tone_mix_only_0_or_7", 32'(bad), 0);
      check("tone_audio_high_count", 32'(hi), 7);

      // ---------------- full scale ----------------
      set_all(16'h0000);
      do_reset(2);
      bad = 0;
      for (int c = 0; c <= 170; c++) begin
         if (c == 4)   set_all(16'hF001);
         if (c == 11)  check("full_chan_c11", 32'(chan_sq), 0);
         if (c == 12)  check("full_chan_c12", 32'(chan_sq), 32'hFF);
         if (c == 56)  check("full_mix_c56", 32'(mix_level), 56);
         if (c == 56)  check("full_audio_c56", 32'(audio_pwm), 0);
         if (c == 112) check("full_mix_c112", 32'(mix_level), 56);
         if (c == 168) check("full_mix_c168", 32'(mix_level), 56);
         if ((c >= 57) && (c <= 168) && !audio_pwm) bad++;
         cyc();
      end
      check("full_audio_const_high", 32'(bad), 0);

      // ---------------- disable mid-tone ----------------
      set_all(16'h0000);
      rst = 1'b1;
      regs[0] = 16'hF003;
      do_reset(2);
      for (int c = 0; c <= 45; c++) begin
         if (c == 20) begin
            check("dis_sq_before", 32'(chan_sq[0]), 1);
            regs[0] = 16'h7003;
         end
         if (c == 21) check("dis_sq_cleared", 32'(chan_sq[0]), 0);
         if (c == 24) regs[0] = 16'hF003;
         if (c == 39) check("dis_low_phase_c39", 32'(chan_sq[0]), 0);
         if (c == 40) check("dis_retoggle_c40", 32'(chan_sq[0]), 1);
         cyc();
      end

      // ---------------- period shrink 100 -> 5 ----------------
      set_all(16'h0000);
      rst = 1'b1;
      regs[0] = 16'hF064;
      do_reset(2);
      for (int c = 0; c <= 110; c++) begin
         if (c == 84)  regs[0] = 16'hF005;
         if (c == 88)  check("shrink_no_toggle_on_load", 32'(chan_sq[0]), 0);
         if (c == 107) check("shrink_sq_c107", 32'(chan_sq[0]), 0);
         if (c == 108) check("shrink_sq_c108", 32'(chan_sq[0]), 1);
         cyc();
      end

      // ---------------- mid-operation reset ----------------
      set_all(16'h0000);
      rst = 1'b1;
      regs[0] = 16'hF003;
      do_reset(2);
      repeat (170) cyc();
      check("mrst_mix_before", 32'(mix_level), 7);
      check("mrst_sq_before", 32'(chan_sq[0]), 1);
      do_reset(1);
      check("mrst_mix", 32'(mix_level), 0);
      check("mrst_audio", 32'(audio_pwm), 0);
      check("mrst_chan_sq", 32'(chan_sq), 0);
      check("mrst_strobe", 32'(sample_strobe), 0);
      for (int c = 0; c <= 16; c++) begin
         if (c == 15) check("mrst_sq_c15", 32'(chan_sq[0]), 0);
         if (c == 16) check("mrst_sq_c16", 32'(chan_sq[0]), 1);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
